// File: rtl/tim_arbiter.sv
// rtl/tim_arbiter.sv - two-requester arbiter in front of a single-cycle TIM port
//
// Purpose: shares one TIM port between two requesters. Each requester issues
// 1-cycle mem_valid pulses. A request that loses a tie is parked in that
// requester's pending buffer and issued on a later cycle. Ties alternate
// between the requesters. Requests outside the TIM window never reach the TIM
// and are answered with an error response on the next cycle.
//
// Ports:
//   clock     - single clock; all state changes on its rising edge
//   reset     - asynchronous, active-low reset
//   req0_in   - requester 0 request (mem_valid pulse, addr, wdata, wstrb)
//   req0_out  - requester 0 response (mem_ready, mem_error, mem_rdata)
//   req1_in   - requester 1 request
//   req1_out  - requester 1 response
//   tim_in    - request to the shared TIM; driven in the grant cycle
//   tim_out   - TIM response; mem_ready one cycle after an accepted mem_valid

package tim_arbiter_pkg;
   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [63:0] mem_wdata;
      logic [7:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic        mem_error;
      logic [63:0] mem_rdata;
   } mem_out_type;
endpackage

module tim_arbiter
   import tim_arbiter_pkg::*;
#(
   parameter int unsigned TIM_DEPTH = 1024,
   parameter int unsigned TIM_WIDTH = 1,
   parameter logic [31:0] TIM_BASE  = 32'h0008_0000,
   parameter logic [31:0] TIM_SIZE  = TIM_DEPTH * TIM_WIDTH * 8
) (
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  req0_in,
   output mem_out_type req0_out,
   input  mem_in_type  req1_in,
   output mem_out_type req1_out,
   output mem_in_type  tim_in,
   input  mem_out_type tim_out
);

   // One extra bit so that a window ending at 2**32 does not wrap.
   localparam logic [32:0] WIN_LO = {1'b0, TIM_BASE};
   localparam logic [32:0] WIN_HI = {1'b0, TIM_BASE} + {1'b0, TIM_SIZE};

   mem_in_type  req_in   [2];
   mem_in_type  pend_q   [2];
   mem_in_type  cand_req [2];
   mem_out_type rsp      [2];

   logic [1:0] pend_v;
   logic [1:0] err_sched;
   logic       last_grant;
   logic       owner;
   logic       inflight;

   logic [1:0] fresh;
   logic [1:0] in_win;
   logic [1:0] cand;
   logic       gnt_v;
   logic       gnt_id;

   assign req_in[0] = req0_in;
   assign req_in[1] = req1_in;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         // A port with a parked request ignores new pulses. A port that is
         // receiving its response this cycle is free again, which is what
         // allows back-to-back issue. Pulses during reset are dropped.
         fresh[p]    = reset && req_in[p].mem_valid && !pend_v[p];
         in_win[p]   = ({1'b0, req_in[p].mem_addr} >= WIN_LO) &&
                       ({1'b0, req_in[p].mem_addr} <  WIN_HI);
         cand[p]     = pend_v[p] || (fresh[p] && in_win[p]);
         cand_req[p] = pend_v[p] ? pend_q[p] : req_in[p];
      end

      gnt_v  = |cand;
      // On a tie the requester that did not win last time gets the slot.
      gnt_id = (&cand) ? ~last_grant : cand[1];

      tim_in = '0;
      if (gnt_v) begin
         tim_in           = cand_req[gnt_id];
         tim_in.mem_valid = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_v     <= '0;
         pend_q[0]  <= '0;
         pend_q[1]  <= '0;
         err_sched  <= '0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         inflight   <= 1'b0;
      end else begin
         inflight <= gnt_v;
         if (gnt_v) begin
            owner      <= gnt_id;
            last_grant <= gnt_id;
         end
         for (int p = 0; p < 2; p++) begin
            err_sched[p] <= fresh[p] && !in_win[p];
            if (gnt_v && (gnt_id == 1'(p))) begin
               pend_v[p] <= 1'b0;
            end else if (fresh[p] && in_win[p]) begin
               pend_v[p] <= 1'b1;
               pend_q[p] <= req_in[p];
            end
         end
      end
   end

   // Responses are steered from the registered owner. The TIM return and an
   // error response can never target the same port in one cycle, because an
   // out-of-range pulse is only taken from a port with nothing parked.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rsp[p] = '0;
         if (inflight && (owner == 1'(p))) begin
            rsp[p].mem_ready = tim_out.mem_ready;
            rsp[p].mem_error = tim_out.mem_error;
            rsp[p].mem_rdata = tim_out.mem_rdata;
         end else if (err_sched[p]) begin
            rsp[p].mem_ready = 1'b1;
            rsp[p].mem_error = 1'b1;
         end
      end
   end

   assign req0_out = rsp[0];
   assign req1_out = rsp[1];

endmodule

// File: doc/tim_arbiter.md
TIM_ARBITER -- requirements
Module: tim_arbiter

Interface
REQ-001 Parameter TIM_BASE, default 32'h0008_0000, byte base address of the TIM window.
REQ-002 Parameter TIM_SIZE, default TIM_DEPTH*TIM_WIDTH*8, byte size of the TIM window.
REQ-003 Port clock  input  1  single clock; all state on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req0_in  input  mem_in_type  requester 0 request (mem_valid pulse, mem_addr, mem_wdata, mem_wstrb).
REQ-006 Port req0_out  output  mem_out_type  requester 0 response.
REQ-007 Port req1_in  input  mem_in_type  requester 1 request.
REQ-008 Port req1_out  output  mem_out_type  requester 1 response.
REQ-009 Port tim_in  output  mem_in_type  request to the shared TIM port.
REQ-010 Port tim_out  input  mem_out_type  TIM response; mem_ready exactly 1 cycle after an accepted mem_valid.

Function
REQ-011 The block SHALL treat mem_valid as a 1-cycle pulse; one request per requester outstanding until its mem_ready.
REQ-012 The block SHALL hold one pending buffer per requester (valid flag + addr, wdata, wstrb).
REQ-013 Requester candidate each cycle: pending buffer if valid, else new in-range req*_in with mem_valid=1.
REQ-014 In-range: TIM_BASE <= mem_addr < TIM_BASE+TIM_SIZE, unsigned compare at full mem_addr width.
REQ-015 One candidate: grant it; two candidates: grant the requester != last_grant; last_grant updates on every grant.
REQ-016 The granted request SHALL drive tim_in combinationally in the grant cycle with mem_valid=1; tim_in SHALL be all-zero when no grant.
REQ-017 A non-granted new in-range request SHALL be captured into its pending buffer; a granted pending buffer SHALL clear on that edge.
REQ-018 The block SHALL register owner (1 bit) and inflight on each grant; next cycle tim_out.mem_rdata/mem_ready/mem_error route to owner's req*_out.
REQ-019 The non-owner response port SHALL drive mem_ready=0, mem_error=0, mem_rdata=0 unless REQ-020 applies.
REQ-020 Out-of-range new request: not forwarded, no TIM slot used; next cycle that port drives mem_ready=1, mem_error=1, mem_rdata=0.
REQ-021 A new mem_valid on a port with pending, in-flight or error response scheduled SHALL be ignored: no capture, no response.
REQ-022 Latency: uncontended 1 cycle (valid to ready); loser of a tie 2 cycles; worst case 2 cycles, one TIM issue per cycle sustained.
REQ-023 Simultaneous out-of-range on one port and grant on the other SHALL both complete in the following cycle.
REQ-024 mem_wstrb passes unmodified; wstrb=0 is a read, non-zero a write; rdata returned for both.

Reset
REQ-025 While reset=0: pending valid flags, inflight and error-scheduled flags = 0; last_grant = 1 (requester 0 wins first tie).
REQ-026 While reset=0: all req*_out fields = 0, tim_in all fields = 0.
REQ-027 A TIM response arriving in the first cycle after reset release SHALL be discarded (inflight=0).
REQ-028 Requests whose mem_valid pulse coincides with reset=0 SHALL be lost with no response.

Verification
REQ-029 Solo: req0 read addr TIM_BASE+8, cycle 0 -> tim_in.mem_valid=1 cycle 0; req0_out.mem_ready=1 cycle 1 with TIM rdata; req1_out idle.
REQ-030 Tie after reset: req0 & req1 valid cycle 0 -> req0 issued cycle 0, req1 issued cycle 1; ready on req0 cycle 1, req1 cycle 2.
REQ-031 Second tie: repeat REQ-030 immediately -> req1 now wins (last_grant=0); alternation held over 8 back-to-back ties.
REQ-032 Out-of-range: req1 addr TIM_BASE+TIM_SIZE, req0 in-range same cycle -> req0 issued cycle 0; cycle 1 req0 ready/error=0, req1 ready/error=1, rdata=0.
REQ-033 Write then read: req0 write wdata=64'hDEADBEEF_01234567 strb=8'hFF, then read same addr -> read rdata equals written value.
REQ-034 Reset mid-op: assert reset with req1 pending and req0 in flight -> all outputs 0 during reset; no mem_ready on either port after release.
